time_down: RTL

- Count-down timer, the reverse-direction counterpart of the team's count-up one-shot timer.
- Loads a programmed value on trigger and decrements once per clock to zero.
- Emits a one-cycle timeout pulse and a sticky interrupt flag on expiry.
- Supports one-shot and periodic (auto-reload) modes, pause and abort; drives timeout/irq to the interrupt aggregator and cnt to the status register block.

---
 rtl/time_down.sv | 98 +++++++++
 1 files changed

// File: rtl/time_down.sv
// Count-down timer: loads a programmed value on trig, decrements to zero, and
// flags expiry with a one-cycle timeout pulse and a sticky irq. One-shot or auto-reload.
module time_down #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic             cfg_periodic,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             paused,
  output logic             timeout,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] load_reg, load_nx;
  logic [WIDTH-1:0] cnt_nx;
  logic             timeout_nx;
  logic             irq_nx;

  function automatic logic is_last(input logic [WIDTH-1:0] v);
    return (v <= WIDTH'(1));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      load_reg <= '0;
      timeout  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      load_reg <= load_nx;
      timeout  <= timeout_nx;
      irq      <= irq_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    load_nx    = load_reg;
    timeout_nx = 1'b0;
    // irq_clr only matters when no expiry happens this cycle; expiry overrides below
    irq_nx     = irq & ~irq_clr;

    if (stop) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (trig && (cfg_load != '0)) begin
      load_nx  = cfg_load;
      cnt_nx   = cfg_load;
      state_nx = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (pause) begin
            state_nx = PAUSE;
          end else if (!is_last(cnt)) begin
            cnt_nx = cnt - WIDTH'(1);
          end else begin
            timeout_nx = 1'b1;
            irq_nx     = 1'b1;
            if (cfg_periodic) begin
              cnt_nx = load_reg;
            end else begin
              cnt_nx   = '0;
              state_nx = IDLE;
            end
          end
        end
        PAUSE: begin
          // leaving PAUSE costs one hold cycle before decrement resumes
          if (!pause) state_nx = RUN;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == RUN) || (state == PAUSE);
  assign paused = (state == PAUSE);

endmodule
